// File: rtl/assoc_cache.sv
// Fully associative cache with true-LRU replacement, a single-ported memory
// side and optional write-back (write-allocate) or write-through operation.
module assoc_cache #(
    parameter int D_WIDTH    = 8,
    parameter int A_WIDTH    = 8,
    parameter int ENTRIES    = 4,
    parameter int WRITE_BACK = 1
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               req,
    input  logic               rw,
    input  logic [A_WIDTH-1:0] addr,
    input  logic [D_WIDTH-1:0] wdata,
    input  logic               flush,
    output logic [D_WIDTH-1:0] rdata,
    output logic               odv,
    output logic               busy,
    output logic               mem_ce,
    output logic               mem_rw,
    output logic [A_WIDTH-1:0] mem_addr,
    output logic [D_WIDTH-1:0] mem_wdata,
    input  logic [D_WIDTH-1:0] mem_rdata,
    input  logic               mem_ack
);

    localparam int IW = $clog2(ENTRIES);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WB    = 3'd1;
    localparam logic [2:0] S_FILL  = 3'd2;
    localparam logic [2:0] S_WT    = 3'd3;
    localparam logic [2:0] S_FLUSH = 3'd4;

    typedef logic [ENTRIES-1:0][IW-1:0] ageVec_t;

    logic [ENTRIES-1:0] r_valid;
    logic [ENTRIES-1:0] r_dirty;
    logic [A_WIDTH-1:0] r_tag  [ENTRIES];
    logic [D_WIDTH-1:0] r_data [ENTRIES];
    ageVec_t            r_age;

    logic [2:0]         r_state;
    logic [A_WIDTH-1:0] r_reqAddr;
    logic               r_reqRw;
    logic [D_WIDTH-1:0] r_reqWdata;
    logic [IW-1:0]      r_victim;
    logic [IW-1:0]      r_flushIdx;

    logic [D_WIDTH-1:0] r_rdata;
    logic               r_odv;
    logic               r_busy;
    logic               r_memCe;
    logic               r_memRw;
    logic [A_WIDTH-1:0] r_memAddr;
    logic [D_WIDTH-1:0] r_memWdata;

    logic               w_hit;
    logic [IW-1:0]      w_hitIdx;
    logic               w_anyInv;
    logic [IW-1:0]      w_invIdx;
    logic [IW-1:0]      w_lruIdx;
    logic [IW-1:0]      w_victim;
    logic               w_victimDirty;
    logic               w_anyDirty;
    logic [IW-1:0]      w_dirtyIdx;
    logic [ENTRIES-1:0] w_otherDirty;

    // Touching an entry makes it most recent; entries younger than it age by one.
    function automatic ageVec_t lruTouch(input ageVec_t ages, input logic [IW-1:0] idx);
        ageVec_t       res;
        logic [IW-1:0] old;
        old = ages[idx];
        for (int i = 0; i < ENTRIES; i++) begin
            if (IW'(i) == idx)
                res[i] = IW'(ENTRIES - 1);
            else if (ages[i] > old)
                res[i] = ages[i] - IW'(1);
            else
                res[i] = ages[i];
        end
        return res;
    endfunction

    // Tag match against the incoming address and locate the oldest entry.
    always_comb begin
        w_hit    = 1'b0;
        w_hitIdx = '0;
        w_lruIdx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (r_valid[i] && (r_tag[i] == addr)) begin
                w_hit    = 1'b1;
                w_hitIdx = IW'(i);
            end
            if (r_age[i] == '0)
                w_lruIdx = IW'(i);
        end
    end

    // Lowest-index invalid and dirty entries; the victim prefers an empty slot.
    always_comb begin
        w_anyInv   = 1'b0;
        w_invIdx   = '0;
        w_anyDirty = 1'b0;
        w_dirtyIdx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_anyInv = 1'b1;
                w_invIdx = IW'(i);
            end
            if (r_dirty[i]) begin
                w_anyDirty = 1'b1;
                w_dirtyIdx = IW'(i);
            end
        end
        w_victim      = w_anyInv ? w_invIdx : w_lruIdx;
        w_victimDirty = (WRITE_BACK != 0) && r_valid[w_victim] && r_dirty[w_victim];
        w_otherDirty  = r_dirty;
        w_otherDirty[r_flushIdx] = 1'b0;
    end

    // Request acceptance, miss handling, memory sequencing and flush.
    always_ff @(posedge clk) begin
        if (!clr) begin
            r_state    <= S_IDLE;
            r_valid    <= '0;
            r_dirty    <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_age[i]  <= IW'(i);
                r_tag[i]  <= '0;
                r_data[i] <= '0;
            end
            r_reqAddr  <= '0;
            r_reqRw    <= 1'b0;
            r_reqWdata <= '0;
            r_victim   <= '0;
            r_flushIdx <= '0;
            r_rdata    <= '0;
            r_odv      <= 1'b0;
            r_busy     <= 1'b0;
            r_memCe    <= 1'b0;
            r_memRw    <= 1'b0;
            r_memAddr  <= '0;
            r_memWdata <= '0;
        end else begin
            r_odv <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_reqAddr  <= addr;
                        r_reqRw    <= rw;
                        r_reqWdata <= wdata;
                        r_victim   <= w_victim;
                        if (rw && w_hit) begin
                            r_rdata <= r_data[w_hitIdx];
                            r_age   <= lruTouch(r_age, w_hitIdx);
                            r_odv   <= 1'b1;
                        end else if (rw) begin
                            r_busy  <= 1'b1;
                            r_memCe <= 1'b1;
                            if (w_victimDirty) begin
                                r_state    <= S_WB;
                                r_memRw    <= 1'b0;
                                r_memAddr  <= r_tag[w_victim];
                                r_memWdata <= r_data[w_victim];
                            end else begin
                                r_state   <= S_FILL;
                                r_memRw   <= 1'b1;
                                r_memAddr <= addr;
                            end
                        end else if (WRITE_BACK != 0) begin
                            if (w_hit) begin
                                r_data[w_hitIdx]  <= wdata;
                                r_dirty[w_hitIdx] <= 1'b1;
                                r_age             <= lruTouch(r_age, w_hitIdx);
                                r_odv             <= 1'b1;
                            end else if (w_victimDirty) begin
                                r_state    <= S_WB;
                                r_busy     <= 1'b1;
                                r_memCe    <= 1'b1;
                                r_memRw    <= 1'b0;
                                r_memAddr  <= r_tag[w_victim];
                                r_memWdata <= r_data[w_victim];
                            end else begin
                                r_valid[w_victim] <= 1'b1;
                                r_dirty[w_victim] <= 1'b1;
                                r_tag[w_victim]   <= addr;
                                r_data[w_victim]  <= wdata;
                                r_age             <= lruTouch(r_age, w_victim);
                                r_odv             <= 1'b1;
                            end
                        end else begin
                            if (w_hit) begin
                                r_data[w_hitIdx] <= wdata;
                                r_age            <= lruTouch(r_age, w_hitIdx);
                            end
                            r_state    <= S_WT;
                            r_busy     <= 1'b1;
                            r_memCe    <= 1'b1;
                            r_memRw    <= 1'b0;
                            r_memAddr  <= addr;
                            r_memWdata <= wdata;
                        end
                    end else if (flush) begin
                        if (w_anyDirty) begin
                            r_state    <= S_FLUSH;
                            r_busy     <= 1'b1;
                            r_flushIdx <= w_dirtyIdx;
                            r_memCe    <= 1'b1;
                            r_memRw    <= 1'b0;
                            r_memAddr  <= r_tag[w_dirtyIdx];
                            r_memWdata <= r_data[w_dirtyIdx];
                        end else begin
                            r_odv <= 1'b1;
                        end
                    end
                end
                S_WB: begin
                    if (r_memCe && mem_ack) begin
                        r_dirty[r_victim] <= 1'b0;
                        r_memCe    <= 1'b0;
                        r_memRw    <= 1'b0;
                        r_memAddr  <= '0;
                        r_memWdata <= '0;
                        if (r_reqRw) begin
                            r_state <= S_FILL;
                        end else begin
                            r_valid[r_victim] <= 1'b1;
                            r_dirty[r_victim] <= 1'b1;
                            r_tag[r_victim]   <= r_reqAddr;
                            r_data[r_victim]  <= r_reqWdata;
                            r_age             <= lruTouch(r_age, r_victim);
                            r_odv             <= 1'b1;
                            r_busy            <= 1'b0;
                            r_state           <= S_IDLE;
                        end
                    end
                end
                S_FILL: begin
                    if (!r_memCe) begin
                        r_memCe   <= 1'b1;
                        r_memRw   <= 1'b1;
                        r_memAddr <= r_reqAddr;
                    end else if (mem_ack) begin
                        r_valid[r_victim] <= 1'b1;
                        r_dirty[r_victim] <= 1'b0;
                        r_tag[r_victim]   <= r_reqAddr;
                        r_data[r_victim]  <= mem_rdata;
                        r_age             <= lruTouch(r_age, r_victim);
                        r_rdata           <= mem_rdata;
                        r_odv             <= 1'b1;
                        r_busy            <= 1'b0;
                        r_state           <= S_IDLE;
                        r_memCe           <= 1'b0;
                        r_memRw           <= 1'b0;
                        r_memAddr         <= '0;
                    end
                end
                S_WT: begin
                    if (r_memCe && mem_ack) begin
                        r_odv      <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                        r_memCe    <= 1'b0;
                        r_memRw    <= 1'b0;
                        r_memAddr  <= '0;
                        r_memWdata <= '0;
                    end
                end
                S_FLUSH: begin
                    if (!r_memCe) begin
                        r_flushIdx <= w_dirtyIdx;
                        r_memCe    <= 1'b1;
                        r_memRw    <= 1'b0;
                        r_memAddr  <= r_tag[w_dirtyIdx];
                        r_memWdata <= r_data[w_dirtyIdx];
                    end else if (mem_ack) begin
                        r_dirty[r_flushIdx] <= 1'b0;
                        r_memCe    <= 1'b0;
                        r_memRw    <= 1'b0;
                        r_memAddr  <= '0;
                        r_memWdata <= '0;
                        if (w_otherDirty == '0) begin
                            r_odv   <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_memCe <= 1'b0;
                end
            endcase
        end
    end

    assign rdata     = r_rdata;
    assign odv       = r_odv;
    assign busy      = r_busy;
    assign mem_ce    = r_memCe;
    assign mem_rw    = r_memRw;
    assign mem_addr  = r_memAddr;
    assign mem_wdata = r_memWdata;

endmodule

// File: tb/tb_assoc_cache.sv
// Self-checking bench for assoc_cache: a write-back instance (index 0) and a
// write-through instance (index 1), each with its own simulated memory.
module tb_assoc_cache;

    typedef struct {
        int         d;
        bit         rw;
        logic [7:0] a;
        logic [7:0] dat;
    } txn_t;

    typedef struct {
        bit         rw;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] expRd;
        int         expOps;
        logic [7:0] wbAddr;
        logic [7:0] wbData;
    } vec_t;

    logic       clk;
    logic       clr;
    logic       rw;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       reqV   [2];
    logic       flushV [2];
    logic [7:0] rdataS [2];
    logic       odvS   [2];
    logic       busyS  [2];
    logic       memCe  [2];
    logic       memRw  [2];
    logic [7:0] memAddr  [2];
    logic [7:0] memWdata [2];
    logic [7:0] memRdata [2];
    logic       memAck   [2];

    logic [7:0] memArr [2][256];
    txn_t       memLog [$];
    int         ackDelay;

    int         nCompared;
    int         nMismatched;

    // reference model state
    bit         mValid [4];
    bit         mDirty [4];
    logic [7:0] mTag   [4];
    int         lruQ   [$];
    logic [7:0] shadow [256];

    vec_t       vecs [$];
    logic [7:0] rd;
    int         lat, nOps, st, expOps, h, v, extra;
    logic       bsy, r;
    logic [7:0] a, wd, expRd;

    assoc_cache #(.D_WIDTH(8), .A_WIDTH(8), .ENTRIES(4), .WRITE_BACK(1)) dut (
        .clk(clk), .clr(clr), .req(reqV[0]), .rw(rw), .addr(addr), .wdata(wdata),
        .flush(flushV[0]), .rdata(rdataS[0]), .odv(odvS[0]), .busy(busyS[0]),
        .mem_ce(memCe[0]), .mem_rw(memRw[0]), .mem_addr(memAddr[0]),
        .mem_wdata(memWdata[0]), .mem_rdata(memRdata[0]), .mem_ack(memAck[0])
    );

    assoc_cache #(.D_WIDTH(8), .A_WIDTH(8), .ENTRIES(4), .WRITE_BACK(0)) dutWt (
        .clk(clk), .clr(clr), .req(reqV[1]), .rw(rw), .addr(addr), .wdata(wdata),
        .flush(flushV[1]), .rdata(rdataS[1]), .odv(odvS[1]), .busy(busyS[1]),
        .mem_ce(memCe[1]), .mem_rw(memRw[1]), .mem_addr(memAddr[1]),
        .mem_wdata(memWdata[1]), .mem_rdata(memRdata[1]), .mem_ack(memAck[1])
    );

    // free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // memory responder: acks ackDelay cycles after mem_ce rises, logs each cycle
    task automatic responder();
        int cnt [2];
        cnt[0] = 0;
        cnt[1] = 0;
        memAck[0] = 1'b0;
        memAck[1] = 1'b0;
        memRdata[0] = '0;
        memRdata[1] = '0;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (memAck[d]) begin
                    memAck[d] = 1'b0;
                    cnt[d] = 0;
                end else if (memCe[d] === 1'b1) begin
                    cnt[d]++;
                    if (cnt[d] >= ackDelay) begin
                        memAck[d] = 1'b1;
                        if (memRw[d]) memRdata[d] = memArr[d][memAddr[d]];
                        else memArr[d][memAddr[d]] = memWdata[d];
                        memLog.push_back('{d, memRw[d], memAddr[d], memRw[d] ? memRdata[d] : memWdata[d]});
                    end
                end else begin
                    cnt[d] = 0;
                end
            end
        end
    endtask

    task automatic applyReset();
        @(negedge clk);
        clr = 1'b0;
        reqV[0] = 1'b0;
        reqV[1] = 1'b0;
        flushV[0] = 1'b0;
        flushV[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        clr = 1'b1;
    endtask

    task automatic waitOdv(input int d, output logic [7:0] rdo, output int latO, output logic bsyO);
        latO = 0;
        rdo  = '0;
        bsyO = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (odvS[d] === 1'b1) begin
                latO = c;
                rdo  = rdataS[d];
                bsyO = busyS[d];
                break;
            end
        end
        if (latO == 0) checkOutput("odvTimeout", 0, 1);
    endtask

    task automatic applyStimulus(input int d, input logic rwI, input logic [7:0] aI, input logic [7:0] wdI,
                                 output logic [7:0] rdo, output int latO, output int opsO,
                                 output int startO, output logic bsyO);
        @(negedge clk);
        startO = memLog.size();
        rw = rwI;
        addr = aI;
        wdata = wdI;
        reqV[d] = 1'b1;
        @(posedge clk);
        #1 reqV[d] = 1'b0;
        waitOdv(d, rdo, latO, bsyO);
        opsO = memLog.size() - startO;
    endtask

    task automatic applyFlush(input int d, output int latO, output int opsO, output int startO);
        logic [7:0] dummy;
        logic       b;
        @(negedge clk);
        startO = memLog.size();
        flushV[d] = 1'b1;
        @(posedge clk);
        #1 flushV[d] = 1'b0;
        waitOdv(d, dummy, latO, b);
        opsO = memLog.size() - startO;
    endtask

    function automatic int modelLookup(input logic [7:0] aI);
        for (int i = 0; i < 4; i++)
            if (mValid[i] && mTag[i] == aI) return i;
        return -1;
    endfunction

    function automatic int modelVictim();
        for (int i = 0; i < 4; i++)
            if (!mValid[i]) return i;
        return lruQ[0];
    endfunction

    task automatic modelTouch(input int idx);
        for (int k = 0; k < lruQ.size(); k++) begin
            if (lruQ[k] == idx) begin
                lruQ.delete(k);
                break;
            end
        end
        lruQ.push_back(idx);
    endtask

    // main test sequence
    initial begin
        nCompared = 0;
        nMismatched = 0;
        clr = 1'b0;
        rw = 1'b1;
        addr = '0;
        wdata = '0;
        reqV[0] = 1'b0;
        reqV[1] = 1'b0;
        flushV[0] = 1'b0;
        flushV[1] = 1'b0;
        ackDelay = 3;
        for (int i = 0; i < 256; i++) begin
            memArr[0][i] = 8'(i) ^ 8'h5A;
            memArr[1][i] = 8'(i) ^ 8'h5A;
        end
        memArr[0][8'h10] = 8'hA5;
        fork
            responder();
        join_none

        // reset state
        applyReset();
        checkOutput("rstOdv", odvS[0], 0);
        checkOutput("rstBusy", busyS[0], 0);
        checkOutput("rstMemCe", memCe[0], 0);
        checkOutput("rstRdata", rdataS[0], 0);
        checkOutput("rstMemAddr", memAddr[0], 0);
        checkOutput("rstMemWdata", memWdata[0], 0);

        // cold read then repeat hit
        applyStimulus(0, 1'b1, 8'h10, 8'h00, rd, lat, nOps, st, bsy);
        checkOutput("coldOps", nOps, 1);
        if (nOps >= 1) begin
            checkOutput("coldTxnRw", memLog[st].rw, 1);
            checkOutput("coldTxnAddr", memLog[st].a, 8'h10);
        end
        checkOutput("coldRdata", rd, 8'hA5);
        applyStimulus(0, 1'b1, 8'h10, 8'h00, rd, lat, nOps, st, bsy);
        checkOutput("repeatOps", nOps, 0);
        checkOutput("repeatLat", lat, 1);
        checkOutput("repeatRdata", rd, 8'hA5);
        checkOutput("repeatBusy", bsy, 0);

        // LRU eviction and dirty eviction table
        applyReset();
        vecs.push_back('{1'b1, 8'h01, 8'h00, 8'h5B, 1, 8'h00, 8'h00});
        vecs.push_back('{1'b1, 8'h02, 8'h00, 8'h58, 1, 8'h00, 8'h00});
        vecs.push_back('{1'b1, 8'h03, 8'h00, 8'h59, 1, 8'h00, 8'h00});
        vecs.push_back('{1'b1, 8'h04, 8'h00, 8'h5E, 1, 8'h00, 8'h00});
        vecs.push_back('{1'b1, 8'h01, 8'h00, 8'h5B, 0, 8'h00, 8'h00});
        vecs.push_back('{1'b1, 8'h05, 8'h00, 8'h5F, 1, 8'h00, 8'h00});
        vecs.push_back('{1'b1, 8'h01, 8'h00, 8'h5B, 0, 8'h00, 8'h00});
        vecs.push_back('{1'b1, 8'h02, 8'h00, 8'h58, 1, 8'h00, 8'h00});
        vecs.push_back('{1'b0, 8'h20, 8'h3C, 8'h00, 0, 8'h00, 8'h00});
        vecs.push_back('{1'b1, 8'h30, 8'h00, 8'h6A, 1, 8'h00, 8'h00});
        vecs.push_back('{1'b1, 8'h31, 8'h00, 8'h6B, 1, 8'h00, 8'h00});
        vecs.push_back('{1'b1, 8'h32, 8'h00, 8'h68, 1, 8'h00, 8'h00});
        vecs.push_back('{1'b1, 8'h33, 8'h00, 8'h69, 2, 8'h20, 8'h3C});
        vecs.push_back('{1'b1, 8'h20, 8'h00, 8'h3C, 1, 8'h00, 8'h00});
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(0, vecs[i].rw, vecs[i].addr, vecs[i].wdata, rd, lat, nOps, st, bsy);
            checkOutput($sformatf("vec%0d_ops", i), nOps, vecs[i].expOps);
            if (vecs[i].rw) checkOutput($sformatf("vec%0d_rdata", i), rd, vecs[i].expRd);
            if (vecs[i].expOps == 0) checkOutput($sformatf("vec%0d_hitLat", i), lat, 1);
            if (vecs[i].expOps == 2 && nOps == 2) begin
                checkOutput($sformatf("vec%0d_wbRw", i), memLog[st].rw, 0);
                checkOutput($sformatf("vec%0d_wbAddr", i), memLog[st].a, vecs[i].wbAddr);
                checkOutput($sformatf("vec%0d_wbData", i), memLog[st].dat, vecs[i].wbData);
            end
            if (vecs[i].rw && vecs[i].expOps >= 1 && nOps >= 1) begin
                checkOutput($sformatf("vec%0d_fillRw", i), memLog[st + nOps - 1].rw, 1);
                checkOutput($sformatf("vec%0d_fillAddr", i), memLog[st + nOps - 1].a, vecs[i].addr);
            end
        end

        // write-through instance: no allocate on write miss
        applyStimulus(1, 1'b0, 8'h08, 8'h77, rd, lat, nOps, st, bsy);
        checkOutput("wtOps", nOps, 1);
        if (nOps == 1) begin
            checkOutput("wtTxnRw", memLog[st].rw, 0);
            checkOutput("wtTxnAddr", memLog[st].a, 8'h08);
            checkOutput("wtTxnData", memLog[st].dat, 8'h77);
        end
        applyStimulus(1, 1'b1, 8'h08, 8'h00, rd, lat, nOps, st, bsy);
        checkOutput("wtReadMissOps", nOps, 1);
        checkOutput("wtReadMissData", rd, 8'h77);
        applyStimulus(1, 1'b0, 8'h08, 8'h99, rd, lat, nOps, st, bsy);
        checkOutput("wtHitWriteOps", nOps, 1);
        applyStimulus(1, 1'b1, 8'h08, 8'h00, rd, lat, nOps, st, bsy);
        checkOutput("wtReadHitOps", nOps, 0);
        checkOutput("wtReadHitData", rd, 8'h99);

        // flush with dirty entries 0 and 2
        applyReset();
        applyStimulus(0, 1'b0, 8'h40, 8'hD0, rd, lat, nOps, st, bsy);
        applyStimulus(0, 1'b1, 8'h41, 8'h00, rd, lat, nOps, st, bsy);
        applyStimulus(0, 1'b0, 8'h42, 8'hD2, rd, lat, nOps, st, bsy);
        applyFlush(0, lat, nOps, st);
        checkOutput("flushOps", nOps, 2);
        if (nOps == 2) begin
            checkOutput("flush0Addr", memLog[st].a, 8'h40);
            checkOutput("flush0Data", memLog[st].dat, 8'hD0);
            checkOutput("flush1Rw", memLog[st + 1].rw, 0);
            checkOutput("flush1Addr", memLog[st + 1].a, 8'h42);
            checkOutput("flush1Data", memLog[st + 1].dat, 8'hD2);
        end
        extra = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (odvS[0] === 1'b1) extra++;
        end
        checkOutput("flushSingleOdv", extra, 0);
        applyFlush(0, lat, nOps, st);
        checkOutput("flush2Ops", nOps, 0);
        checkOutput("flush2Lat", lat, 1);

        // reset in the middle of a fill
        applyReset();
        ackDelay = 10;
        @(negedge clk);
        rw = 1'b1;
        addr = 8'h50;
        reqV[0] = 1'b1;
        @(posedge clk);
        #1 reqV[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("midFillCe", memCe[0], 1);
        clr = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("midRstCe", memCe[0], 0);
        checkOutput("midRstBusy", busyS[0], 0);
        checkOutput("midRstAddr", memAddr[0], 0);
        @(negedge clk);
        clr = 1'b1;
        ackDelay = 2;
        applyStimulus(0, 1'b1, 8'h50, 8'h00, rd, lat, nOps, st, bsy);
        checkOutput("afterRstMiss", nOps, 1);
        checkOutput("afterRstData", rd, 8'h50 ^ 8'h5A);

        // randomized traffic against the LRU-list model
        applyReset();
        for (int i = 0; i < 4; i++) begin
            mValid[i] = 1'b0;
            mDirty[i] = 1'b0;
            mTag[i] = '0;
        end
        lruQ.delete();
        for (int i = 0; i < 4; i++) lruQ.push_back(i);
        for (int i = 0; i < 256; i++) shadow[i] = memArr[0][i];
        for (int n = 0; n < 300; n++) begin
            ackDelay = $urandom_range(1, 4);
            if ($urandom_range(0, 11) == 0) begin
                expOps = 0;
                for (int i = 0; i < 4; i++) begin
                    if (mDirty[i]) expOps++;
                    mDirty[i] = 1'b0;
                end
                applyFlush(0, lat, nOps, st);
                checkOutput($sformatf("rnd%0d_flushOps", n), nOps, expOps);
            end else begin
                r = 1'($urandom_range(0, 1));
                a = 8'h60 + 8'($urandom_range(0, 7));
                wd = 8'($urandom);
                h = modelLookup(a);
                if (h >= 0) begin
                    expOps = 0;
                    if (!r) mDirty[h] = 1'b1;
                    modelTouch(h);
                end else begin
                    v = modelVictim();
                    expOps = (mValid[v] && mDirty[v]) ? 1 : 0;
                    if (r) expOps++;
                    mValid[v] = 1'b1;
                    mTag[v] = a;
                    mDirty[v] = !r;
                    modelTouch(v);
                end
                expRd = shadow[a];
                if (!r) shadow[a] = wd;
                applyStimulus(0, r, a, wd, rd, lat, nOps, st, bsy);
                checkOutput($sformatf("rnd%0d_ops", n), nOps, expOps);
                if (r) checkOutput($sformatf("rnd%0d_rdata", n), rd, expRd);
            end
        end
        ackDelay = 1;
        applyFlush(0, lat, nOps, st);
        for (int i = 8'h60; i <= 8'h67; i++)
            checkOutput($sformatf("finalMem%0h", i), memArr[0][i], shadow[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
